// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the memory access arbiter: FSM states, grant ids
// and the fixed-priority request selector.
package mem_access_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_EX   = 2'd2,
    GNT_LD   = 2'd3
  } gnt_id_t;

  // Execute beats fetch beats loader; the loader only runs while the CPU is idle.
  function automatic gnt_id_t prio_select(input logic ex_req,
                                          input logic if_req,
                                          input logic ld_req);
    gnt_id_t sel;
    sel = GNT_NONE;
    if (ex_req) begin
      sel = GNT_EX;
    end else if (if_req) begin
      sel = GNT_IF;
    end else if (ld_req) begin
      sel = GNT_LD;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the RAM access phase; zero marks the
// last access cycle.
module mem_wait_counter
  import mem_access_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Saturates at zero so a stray decrement can never wrap to 15.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_access_arbiter.sv
// Single-port RAM arbiter: grants one of fetch/execute/loader per access,
// holds the RAM for WAIT_CYC cycles, then pulses that requester's done.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  input  logic          ex_req,
  input  logic          ex_we,
  input  logic [AW-1:0] ex_addr,
  input  logic [DW-1:0] ex_wdata,
  output logic          ex_done,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rdata,
  output logic          busy
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYC - 1);

  arb_state_t    state, state_next;
  gnt_id_t       grant, gnt_q;
  logic          grant_start;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;

  // Requests are only looked at in IDLE, so nothing can pre-empt an access.
  assign grant       = (state == ARB_IDLE) ? prio_select(ex_req, if_req, ld_req) : GNT_NONE;
  assign grant_start = (grant != GNT_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (grant_start) begin
          state_next = ARB_ACCESS;
          cnt_load   = 1'b1;
        end
      end
      ARB_ACCESS: begin
        if (cnt_zero) begin
          state_next = ARB_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ARB_RESP: begin
        state_next = ARB_IDLE;
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  mem_wait_counter u_wait_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Fetch never writes, so its grant leaves the write-data latch untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= GNT_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (grant_start) begin
      gnt_q <= grant;
      case (grant)
        GNT_EX: begin
          addr_q  <= ex_addr;
          wdata_q <= ex_wdata;
          we_q    <= ex_we;
        end
        GNT_IF: begin
          addr_q <= if_addr;
          we_q   <= 1'b0;
        end
        GNT_LD: begin
          addr_q  <= ld_addr;
          wdata_q <= ld_wdata;
          we_q    <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if ((state == ARB_ACCESS) && cnt_zero && !we_q) begin
      rdata <= mem_rdata;
    end
  end

  assign mem_en    = (state == ARB_ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != ARB_IDLE);

  assign if_done = (state == ARB_RESP) && (gnt_q == GNT_IF);
  assign ex_done = (state == ARB_RESP) && (gnt_q == GNT_EX);
  assign ld_done = (state == ARB_RESP) && (gnt_q == GNT_LD);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter: a WAIT_CYC=2 instance for the main
// scenarios and a WAIT_CYC=1 instance for back-to-back loader writes.
module tb_mem_access_arbiter;

  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int WAIT_CYC = 2;

  typedef struct {
    logic [2:0]    done_bits;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            cycle;
  } exp_t;

  logic          clk, rst_n;
  logic          if_req, ex_req, ex_we, ld_req;
  logic [AW-1:0] if_addr, ex_addr, ld_addr;
  logic [DW-1:0] ex_wdata, ld_wdata;
  logic          if_done, ex_done, ld_done;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, rdata;

  logic          ld_req_1;
  logic [AW-1:0] ld_addr_1, mem_addr_1;
  logic [DW-1:0] ld_wdata_1, mem_wdata_1, rdata_1;
  logic          if_done_1, ex_done_1, ld_done_1, mem_en_1, mem_we_1, busy_1;

  logic [DW-1:0] ram     [256];
  logic [DW-1:0] exp_mem [256];
  logic [DW-1:0] rdata_model;
  exp_t          q[$];
  exp_t          q1[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            en_count = 0, we_count = 0, en_count_1 = 0;

  mem_access_arbiter #(.AW(AW), .DW(DW), .WAIT_CYC(WAIT_CYC)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_done(ex_done),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_done(ld_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rdata(rdata), .busy(busy)
  );

  mem_access_arbiter #(.AW(AW), .DW(DW), .WAIT_CYC(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(1'b0), .if_addr(8'h00), .if_done(if_done_1),
    .ex_req(1'b0), .ex_we(1'b0), .ex_addr(8'h00), .ex_wdata(8'h00), .ex_done(ex_done_1),
    .ld_req(ld_req_1), .ld_addr(ld_addr_1), .ld_wdata(ld_wdata_1), .ld_done(ld_done_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(8'h00), .rdata(rdata_1), .busy(busy_1)
  );

  assign mem_rdata = ram[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Expected read data comes from the bench's own copy of memory contents.
  task automatic pushExpected(input logic [2:0] done_bits, input logic [AW-1:0] addr,
                              input logic we, input logic [DW-1:0] wdata, input int cycle);
    exp_t e;
    e.done_bits = done_bits;
    e.addr      = addr;
    e.we        = we;
    e.wdata     = wdata;
    e.cycle     = cycle;
    e.rdata     = we ? rdata_model : exp_mem[addr];
    if (we) exp_mem[addr] = wdata;
    rdata_model = e.rdata;
    q.push_back(e);
  endtask

  function automatic logic doneOf(input int kind);
    case (kind)
      0:       return if_done;
      1:       return ex_done;
      default: return ld_done;
    endcase
  endfunction

  // kind: 0 fetch, 1 execute, 2 loader. Holds req until done, drops on that edge.
  task automatic applyStimulus(input int kind, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input bit early_drop);
    logic got;
    case (kind)
      0: begin if_addr = addr; if_req = 1'b1; end
      1: begin ex_we = we; ex_addr = addr; ex_wdata = wdata; ex_req = 1'b1; end
      default: begin ld_addr = addr; ld_wdata = wdata; ld_req = 1'b1; end
    endcase
    if (early_drop) begin
      @(posedge clk); #1;
    end else begin
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        got = doneOf(kind);
      end
      if (!got) checkOutput("done_timeout", {31'd0, got}, 32'd1);
      else begin @(posedge clk); #1; end
    end
    case (kind)
      0:       if_req = 1'b0;
      1:       ex_req = 1'b0;
      default: ld_req = 1'b0;
    endcase
  endtask

  // Main scoreboard: every ACCESS cycle and every done pulse is compared to the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      en_count = 0;
      we_count = 0;
    end else begin
      if (mem_en) begin
        en_count++;
        if (mem_we) we_count++;
        if (q.size() > 0) checkOutput("mem_addr_access", {24'd0, mem_addr}, {24'd0, q[0].addr});
      end
      if (if_done || ex_done || ld_done) begin
        if (q.size() == 0) begin
          checkOutput("unexpected_done", {29'd0, if_done, ex_done, ld_done}, 32'd0);
        end else begin
          e = q.pop_front();
          checkOutput("done_id", {29'd0, if_done, ex_done, ld_done}, {29'd0, e.done_bits});
          checkOutput("done_cycle", cyc, e.cycle);
          checkOutput("en_cycles", en_count, WAIT_CYC);
          checkOutput("we_cycles", we_count, e.we ? WAIT_CYC : 0);
          checkOutput("rdata", {24'd0, rdata}, {24'd0, e.rdata});
          checkOutput("mem_addr_held", {24'd0, mem_addr}, {24'd0, e.addr});
          checkOutput("resp_mem_en", {31'd0, mem_en}, 32'd0);
          if (e.we) begin
            checkOutput("mem_wdata", {24'd0, mem_wdata}, {24'd0, e.wdata});
            checkOutput("ram_written", {24'd0, ram[e.addr]}, {24'd0, e.wdata});
          end
        end
        en_count = 0;
        we_count = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      en_count_1 = 0;
    end else begin
      if (mem_en_1) begin
        en_count_1++;
        checkOutput("w1_mem_we", {31'd0, mem_we_1}, 32'd1);
      end
      if (if_done_1 || ex_done_1) checkOutput("w1_wrong_done", {30'd0, if_done_1, ex_done_1}, 32'd0);
      if (ld_done_1) begin
        if (q1.size() == 0) begin
          checkOutput("w1_unexpected_done", {31'd0, ld_done_1}, 32'd0);
        end else begin
          e = q1.pop_front();
          checkOutput("w1_done_cycle", cyc, e.cycle);
          checkOutput("w1_mem_addr", {24'd0, mem_addr_1}, {24'd0, e.addr});
          checkOutput("w1_mem_wdata", {24'd0, mem_wdata_1}, {24'd0, e.wdata});
          checkOutput("w1_en_cycles", en_count_1, 1);
        end
        en_count_1 = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    rst_n = 1'b1;
    if_req = 1'b0; ex_req = 1'b0; ld_req = 1'b0; ex_we = 1'b0;
    if_addr = '0; ex_addr = '0; ld_addr = '0; ex_wdata = '0; ld_wdata = '0;
    ld_req_1 = 1'b0; ld_addr_1 = '0; ld_wdata_1 = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'(i) ^ 8'h5A;
      exp_mem[i] = 8'(i) ^ 8'h5A;
    end
    ram[8'h10] = 8'hA5;
    exp_mem[8'h10] = 8'hA5;
    rdata_model = '0;
    #1 rst_n = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_flags", {26'd0, busy, mem_en, mem_we, if_done, ex_done, ld_done}, 32'd0);
    checkOutput("reset_bus", {8'd0, mem_addr, mem_wdata, rdata}, 32'd0);
    rst_n = 1'b1;

    // Single fetch read.
    @(posedge clk); #1;
    t = cyc;
    pushExpected(3'b100, 8'h10, 1'b0, 8'h00, t + WAIT_CYC + 1);
    applyStimulus(0, 1'b0, 8'h10, 8'h00, 1'b0);

    // All three requesters collide: EX, then IF, then LD, each WAIT_CYC+2 apart.
    t = cyc;
    pushExpected(3'b010, 8'h40, 1'b0, 8'h00, t + 3);
    pushExpected(3'b100, 8'h41, 1'b0, 8'h00, t + 7);
    pushExpected(3'b001, 8'h42, 1'b1, 8'h99, t + 11);
    fork
      applyStimulus(1, 1'b0, 8'h40, 8'h00, 1'b0);
      applyStimulus(0, 1'b0, 8'h41, 8'h00, 1'b0);
      applyStimulus(2, 1'b1, 8'h42, 8'h99, 1'b0);
    join

    // Execute write leaves rdata alone.
    t = cyc;
    pushExpected(3'b010, 8'h20, 1'b1, 8'h3C, t + 3);
    applyStimulus(1, 1'b1, 8'h20, 8'h3C, 1'b0);

    // Fetch request dropped in the first ACCESS cycle.
    t = cyc;
    pushExpected(3'b100, 8'h10, 1'b0, 8'h00, t + 3);
    applyStimulus(0, 1'b0, 8'h10, 8'h00, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("early_drop_idle", {31'd0, busy}, 32'd0);
    checkOutput("early_drop_drained", q.size(), 0);

    // Reset in the middle of a write access.
    @(posedge clk); #1;
    ex_we = 1'b1; ex_addr = 8'h30; ex_wdata = 8'h77; ex_req = 1'b1;
    @(posedge clk); #1;
    checkOutput("pre_reset_we", {31'd0, mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    ex_req = 1'b0;
    #1;
    checkOutput("midreset_flags", {26'd0, busy, mem_en, mem_we, if_done, ex_done, ld_done}, 32'd0);
    checkOutput("midreset_bus", {8'd0, mem_addr, mem_wdata, rdata}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_no_write", {24'd0, ram[8'h30]}, {24'd0, exp_mem[8'h30]});
    rst_n = 1'b1;
    rdata_model = '0;
    @(negedge clk);
    checkOutput("post_reset_idle", {31'd0, busy}, 32'd0);

    // Restart after reset: read back the earlier write.
    @(posedge clk); #1;
    t = cyc;
    pushExpected(3'b100, 8'h20, 1'b0, 8'h00, t + 3);
    applyStimulus(0, 1'b0, 8'h20, 8'h00, 1'b0);

    // WAIT_CYC=1 instance: loader holds req across three writes.
    t = cyc;
    q1.push_back('{3'b001, 8'hA0, 1'b1, 8'h11, 8'h00, t + 2});
    q1.push_back('{3'b001, 8'hA1, 1'b1, 8'h22, 8'h00, t + 5});
    q1.push_back('{3'b001, 8'hA2, 1'b1, 8'h33, 8'h00, t + 8});
    ld_addr_1 = 8'hA0; ld_wdata_1 = 8'h11; ld_req_1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = ld_done_1;
      end
      if (!got) checkOutput("w1_done_timeout", {31'd0, got}, 32'd1);
      @(posedge clk); #1;
      if (k == 0) begin ld_addr_1 = 8'hA1; ld_wdata_1 = 8'h22; end
      else if (k == 1) begin ld_addr_1 = 8'hA2; ld_wdata_1 = 8'h33; end
      else ld_req_1 = 1'b0;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("w1_idle", {31'd0, busy_1}, 32'd0);
    checkOutput("w1_rdata_untouched", {24'd0, rdata_1}, 32'd0);
    checkOutput("w1_drained", q1.size(), 0);
    checkOutput("main_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
